fc_job_scheduler: RTL and testbench

//   Shares one fully-connected inference engine (225-tap, 48-bit result) among N_REQ requesters.

---
 rtl/npu_sched_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 15 +
 rtl/fc_job_scheduler.sv | 109 ++++++++++
 tb/tb_fc_job_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/npu_sched_pkg.sv
// npu_sched_pkg: shared types, constants and the round-robin pick helper for the FC job scheduler
package npu_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } sched_state_e;

    localparam int RESULT_W    = 48;
    localparam int TIMEOUT_CYC = 512;
    localparam int WDOG_W      = $clog2(TIMEOUT_CYC);

    // Rotate req right by ptr, keep the lowest set bit, rotate it back; n <= 8 requesters
    function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
        logic [15:0] mask, dbl, back;
        logic [7:0]  rot, low;
        mask = (16'd1 << n) - 16'd1;
        dbl  = (({8'd0, req} & mask) << n) | ({8'd0, req} & mask);
        rot  = 8'((dbl >> ptr) & mask);
        low  = rot & (~rot + 8'd1);
        back = {8'd0, low} << ptr;
        return 8'((back | (back >> n)) & mask);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set request at or after ptr
module rr_arbiter
    import npu_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant
);

    assign grant = N_REQ'(rr_pick(8'(req), 3'(ptr), N_REQ));

endmodule

// File: rtl/fc_job_scheduler.sv
// fc_job_scheduler: round-robin sharing of one FC engine among N_REQ requesters with a watchdog.
// Define FC_SCHED_PERF_EN to add per-requester job, busy-cycle and timeout counters.
module fc_job_scheduler #(
    parameter int N_REQ       = 4,
    parameter int RESULT_W    = 48,
    parameter int TIMEOUT_CYC = 512
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           i_req,
    output logic [N_REQ-1:0]           o_grant,
    output logic [N_REQ-1:0]           o_done,
    output logic signed [RESULT_W-1:0] o_result,
    output logic                       o_timeout,
    output logic                       o_eng_start,
    input  logic                       i_eng_valid,
    input  logic signed [RESULT_W-1:0] i_eng_result,
    output logic                       o_busy
`ifdef FC_SCHED_PERF_EN
    ,
    output logic [N_REQ-1:0][15:0]    o_job_cnt,
    output logic [31:0]                o_busy_cyc,
    output logic [7:0]                 o_to_cnt
`endif
);
    import npu_sched_pkg::*;

    localparam int PTR_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYC);

    sched_state_e     state;
    logic [PTR_W-1:0] rr_ptr, owner, nxt_ptr;
    logic [WD_W-1:0]  wdog;
    logic [N_REQ-1:0] pick;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (i_req),
        .ptr   (rr_ptr),
        .grant (pick)
    );

    always_comb begin
        owner = '0;
        for (int i = 0; i < N_REQ; i++) owner = o_grant[i] ? PTR_W'(i) : owner;
    end

    assign nxt_ptr     = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + PTR_W'(1);
    assign o_eng_start = state == START;
    assign o_busy      = state != IDLE;
    assign o_done      = (state == RESP) ? o_grant : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            wdog      <= '0;
            o_grant   <= '0;
            o_result  <= '0;
            o_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= |i_req ? ARB : IDLE;
                ARB: begin
                    o_grant <= pick;
                    state   <= |i_req ? START : IDLE;
                end
                START: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    wdog <= wdog + WD_W'(1);
                    if (i_eng_valid) begin
                        o_result  <= i_eng_result;
                        o_timeout <= 1'b0;
                        state     <= RESP;
                    end else if (wdog == WD_W'(TIMEOUT_CYC - 1)) begin
                        o_result  <= '0;
                        o_timeout <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr    <= nxt_ptr;
                    o_grant   <= '0;
                    o_result  <= '0;
                    o_timeout <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FC_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_job_cnt  <= '0;
            o_busy_cyc <= '0;
            o_to_cnt   <= '0;
        end else begin
            if (state == RESP) o_job_cnt[owner] <= o_job_cnt[owner] + 16'd1;
            if (o_busy && o_busy_cyc != '1) o_busy_cyc <= o_busy_cyc + 32'd1;
            if (state == RESP && o_timeout && o_to_cnt != '1) o_to_cnt <= o_to_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fc_job_scheduler.sv
// tb_fc_job_scheduler: directed job table, corner sequences and random jobs against a transaction-level model
module tb_fc_job_scheduler;

    localparam int N = 4;
    localparam int W = 48;
    localparam int T = 512;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] i_req = '0;
    logic [N-1:0] o_grant, o_done;
    logic [W-1:0] o_result;
    logic         o_timeout, o_eng_start, o_busy;
    logic         i_eng_valid = 1'b0;
    logic [W-1:0] i_eng_result = '0;
`ifdef FC_SCHED_PERF_EN
    logic [N-1:0][15:0] job_cnt;
    logic [31:0]        busy_cyc;
    logic [7:0]         to_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;
    int model_ptr = 0;

    always #5 clk = ~clk;

    fc_job_scheduler #(.N_REQ(N), .RESULT_W(W), .TIMEOUT_CYC(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .o_grant      (o_grant),
        .o_done       (o_done),
        .o_result     (o_result),
        .o_timeout    (o_timeout),
        .o_eng_start  (o_eng_start),
        .i_eng_valid  (i_eng_valid),
        .i_eng_result (i_eng_result),
        .o_busy       (o_busy)
`ifdef FC_SCHED_PERF_EN
        ,
        .o_job_cnt    (job_cnt),
        .o_busy_cyc   (busy_cyc),
        .o_to_cnt     (to_cnt)
`endif
    );

    typedef struct {
        logic [3:0]   req;
        int           lat;
        logic [W-1:0] val;
        int           owner;
        logic [W-1:0] res;
        logic         to;
    } job_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    // Start pulses must be isolated and a grant must be one-hot whenever the engine is started
    int gap = 100;
    always @(negedge clk) begin
        if (rst && o_eng_start) begin
            chk("start_gap_ge3", 64'(gap >= 3), 64'd1);
            chk("grant_onehot", 64'($countones(o_grant) == 1), 64'd1);
            gap = 0;
        end else begin
            gap++;
        end
    end

    // lat = 0 means the engine never answers
    task automatic do_job(input logic [3:0] req, input int lat, input logic [W-1:0] val,
                          input int exp_owner, input logic [W-1:0] exp_res, input logic exp_to);
        int   k;
        logic stray;
        i_req = req;
        k = 0;
        while (!o_eng_start && k < 8) begin
            step();
            k++;
        end
        chk("start_latency", 64'(k), 64'd2);
        if (!o_eng_start) return;
        chk("grant", 64'(o_grant), 64'(1 << exp_owner));
        stray = $urandom_range(0, 3) == 0;
        k = 0;
        while (o_done == '0 && k < T + 8) begin
            i_eng_valid  = (lat > 0 && k == lat) || (stray && k == 0);
            i_eng_result = (k == lat) ? val : W'({$urandom, $urandom});
            step();
            k++;
        end
        i_eng_valid = 1'b0;
        chk("done_latency", 64'(k), 64'(lat > 0 ? lat + 1 : T + 1));
        chk("done", 64'(o_done), 64'(1 << exp_owner));
        chk("result", 64'(o_result), 64'(exp_res));
        chk("timeout", 64'(o_timeout), 64'(exp_to));
        i_eng_valid  = exp_to;
        i_eng_result = W'({$urandom, $urandom});
        step();
        i_eng_valid = 1'b0;
        chk("after_done", 64'({o_done, o_timeout, o_grant, o_busy}), 64'd0);
    endtask

    initial begin
        job_t         tbl[10];
        logic         bad;
        logic [3:0]   r;
        int           lat, own;
        logic [W-1:0] val;

        tbl[0] = '{4'b1111, 5,   48'h0000_0000_00A0, 0, 48'h0000_0000_00A0, 1'b0};
        tbl[1] = '{4'b1111, 6,   48'h0000_0000_00A1, 1, 48'h0000_0000_00A1, 1'b0};
        tbl[2] = '{4'b1111, 7,   48'h8000_0000_0001, 2, 48'h8000_0000_0001, 1'b0};
        tbl[3] = '{4'b1111, 8,   48'h7FFF_FFFF_FFFF, 3, 48'h7FFF_FFFF_FFFF, 1'b0};
        tbl[4] = '{4'b1111, 9,   48'h0000_0000_00A4, 0, 48'h0000_0000_00A4, 1'b0};
        tbl[5] = '{4'b0001, 232, 48'h0000_0000_1234, 0, 48'h0000_0000_1234, 1'b0};
        tbl[6] = '{4'b0100, 10,  48'hFFFF_FFFF_FFFB, 2, 48'hFFFF_FFFF_FFFB, 1'b0};
        tbl[7] = '{4'b1000, 0,   48'h0000_0000_BEEF, 3, 48'h0,              1'b1};
        tbl[8] = '{4'b0011, T,   48'h0000_00C0_FFEE, 0, 48'h0000_00C0_FFEE, 1'b0};
        tbl[9] = '{4'b0110, 1,   48'h1234_5678_9ABC, 1, 48'h1234_5678_9ABC, 1'b0};

        repeat (3) step();
        chk("reset_state", 64'({o_grant, o_done, o_result, o_timeout, o_eng_start, o_busy}), 64'd0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 10; i++)
            do_job(tbl[i].req, tbl[i].lat, tbl[i].val, tbl[i].owner, tbl[i].res, tbl[i].to);

        // One-cycle request pulse in IDLE must not start the engine
        i_req = 4'b0010;
        step();
        i_req = '0;
        bad = 1'b0;
        repeat (6) begin
            step();
            bad |= o_eng_start | (|o_grant);
        end
        chk("withdraw", 64'(bad), 64'd0);

        // Reset in the middle of WAIT; rotation restarts from requester 0
        i_req = 4'b0100;
        repeat (12) step();
        chk("busy_in_wait", 64'({o_busy, o_grant}), 64'b1_0100);
        #2 rst = 1'b0;
        #1 chk("reset_async", 64'({o_grant, o_done, o_result, o_timeout, o_eng_start, o_busy}), 64'd0);
        i_req = '0;
        @(negedge clk) rst = 1'b1;
        step();
        do_job(4'b0101, 20, 48'h0000_0000_0055, 0, 48'h0000_0000_0055, 1'b0);
        model_ptr = 1;

        for (int j = 0; j < 40; j++) begin
            r   = 4'($urandom_range(1, 15));
            lat = ($urandom_range(0, 7) == 0) ? 0 : (($urandom_range(0, 9) == 0) ? T : $urandom_range(1, 300));
            val = W'({$urandom, $urandom});
            own = pick(r, model_ptr);
            do_job(r, lat, val, own, (lat > 0) ? val : '0, lat == 0);
            model_ptr = (own + 1) % N;
            if ($urandom_range(0, 1) == 1) begin
                i_req = '0;
                repeat ($urandom_range(0, 3)) step();
            end
        end

`ifdef FC_SCHED_PERF_EN
        i_req = '0;
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        step();
        repeat (3) do_job(4'b0010, 5, 48'h1, 1, 48'h1, 1'b0);
        do_job(4'b0100, 0, 48'h2, 2, 48'h0, 1'b1);
        chk("perf_job_cnt1", 64'(job_cnt[1]), 64'd3);
        chk("perf_job_cnt2", 64'(job_cnt[2]), 64'd1);
        chk("perf_to_cnt", 64'(to_cnt), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not complete, %0d miscompares so far", miscompares);
        $fatal(1);
    end

endmodule
